// File: rtl/if_fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | if_fetch_pkg : shared types and helpers for the instruction-fetch stage     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_fetch_pkg;

    typedef enum logic [0:0] {
        S_READ = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [1:0] LAST_BYTE = 2'd3;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage : if_fetch_pkg

`default_nettype wire

// File: rtl/if_icache.sv
// +----------------------------------------------------------------------------+
// | if_icache : direct-mapped one-word-per-line instruction cache               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_icache #(
    parameter int unsigned LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_addr_i,
    output logic        hit_o,
    output logic [31:0] data_o,
    input  logic        wr_en_i,
    input  logic [29:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_rd_tag;
    logic [IDX_W-1:0] w_wr_idx;

    // Addresses are word addresses, so index/tag start at bit 0.
    assign w_rd_idx = lookup_addr_i[IDX_W-1:0];
    assign w_rd_tag = lookup_addr_i[29:IDX_W];
    assign w_wr_idx = wr_addr_i[IDX_W-1:0];

    assign hit_o  = valid_q[w_rd_idx] && (tag_q[w_rd_idx] == w_rd_tag);
    assign data_o = data_q[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[w_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[w_wr_idx]  <= wr_addr_i[29:IDX_W];
            data_q[w_wr_idx] <= wr_data_i;
        end
    end

endmodule : if_icache

`default_nettype wire

// File: rtl/if_fetch.sv
// +----------------------------------------------------------------------------+
// | if_fetch : byte-serial instruction fetch with valid/ready output and        |
// |            EX redirect; optional icache enabled by defining IF_ICACHE_EN    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_gnt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    input  logic        ready_i
);

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("if_fetch: ICACHE_LINES must be a power of two >= 2");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [2:0]   k_q, k_d;
    logic         pend_q, pend_d;
    logic [1:0]   pend_idx_q, pend_idx_d;

    logic         w_hit;
    logic [31:0]  w_hit_data;
    logic         w_issue;

`ifdef IF_ICACHE_EN
    logic w_cache_hit;
    logic w_fill;

    // Only a line whose last byte lands without an abort is committed.
    assign w_fill = !rst && !redirect_i && (state_q == S_READ) && pend_q &&
                    (pend_idx_q == LAST_BYTE);

    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk          (clk),
        .rst          (rst),
        .lookup_addr_i(fetch_pc_q[31:2]),
        .hit_o        (w_cache_hit),
        .data_o       (w_hit_data),
        .wr_en_i      (w_fill),
        .wr_addr_i    (fetch_pc_q[31:2]),
        .wr_data_i    ({mem_rdata_i, inst_q[23:0]})
    );

    assign w_hit = w_cache_hit && (state_q == S_READ) && (k_q == 3'd0);
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // k_q[2] set means all four bytes have been issued for this word.
    assign w_issue    = !rst && !redirect_i && (state_q == S_READ) && !k_q[2] && !w_hit;
    assign mem_req_o  = w_issue;
    assign mem_addr_o = w_issue ? (fetch_pc_q + {30'd0, k_q[1:0]}) : 32'd0;

    assign pc_o    = fetch_pc_q;
    assign inst_o  = inst_q;
    assign valid_o = (state_q == S_HOLD);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        k_d        = k_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;

        if (redirect_i) begin
            // Dropping pend_d discards any byte still on its way back.
            state_d    = S_READ;
            fetch_pc_d = word_align(redirect_pc_i);
            k_d        = 3'd0;
        end else if (state_q == S_HOLD) begin
            if (ready_i) begin
                state_d    = S_READ;
                fetch_pc_d = fetch_pc_q + 32'd4;
                k_d        = 3'd0;
            end
        end else if (w_hit) begin
            inst_d  = w_hit_data;
            state_d = S_HOLD;
        end else begin
            if (pend_q) begin
                inst_d[{pend_idx_q, 3'b000} +: 8] = mem_rdata_i;
                if (pend_idx_q == LAST_BYTE) begin
                    state_d = S_HOLD;
                    k_d     = 3'd0;
                end
            end
            if (w_issue && mem_gnt_i) begin
                pend_d     = 1'b1;
                pend_idx_d = k_q[1:0];
                k_d        = k_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_READ;
            fetch_pc_q <= RESET_PC;
            inst_q     <= '0;
            k_q        <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_q     <= inst_d;
            k_q        <= k_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

endmodule : if_fetch

`default_nettype wire

// File: tb/tb_if_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_if_fetch : directed self-checking bench for if_fetch                     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_gnt_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        ready_i;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:511];
    logic        pend_v = 1'b0;
    logic [31:0] pend_a = '0;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_gnt_i    (mem_gnt_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    always #5 clk = ~clk;

    // Byte memory: a granted request returns data for the whole next cycle.
    always @(negedge clk) begin
        pend_v = mem_req_o && mem_gnt_i;
        pend_a = mem_addr_o;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata_i = pend_v ? mem[pend_a[8:0]] : 8'hEE;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n = 0;
        while (valid_o !== 1'b1 && n < max_cycles) begin
            tick(); #1;
            n++;
        end
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: valid_o got %b want 1 within %0d cycles", name, valid_o, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_gnt_i = 1'b1; ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        tick(); tick(); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_o); end
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", inst_o); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic();
        for (int c = 0; c < 4; c++) begin
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(c)) begin
                errors++; $display("FAIL basic_req%0d: got req=%b addr=%h want req=1 addr=%h", c, mem_req_o, mem_addr_o, 32'(c));
            end
            tick(); #1;
        end
        checks++; if (mem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_c4: got req=%b valid=%b want req=0 valid=0", mem_req_o, valid_o);
        end
        tick(); #1;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_c5: got %b want 1", valid_o); end
        checks++; if (inst_o !== 32'h0000_0013) begin errors++; $display("FAIL basic_inst: got %h want 00000013", inst_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 0", pc_o); end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin tick(); #1; end
            checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h13 || mem_req_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b pc=%h inst=%h req=%b want 1/0/13/0", c, valid_o, pc_o, inst_o, mem_req_o);
            end
        end
        tick(); ready_i = 1'b1; #1;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_xfer_valid: got %b want 1", valid_o); end
        tick(); ready_i = 1'b0; #1;
        checks++; if (valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4 || pc_o !== 32'h4) begin
            errors++; $display("FAIL bp_next: got valid=%b req=%b addr=%h pc=%h want 0/1/4/4", valid_o, mem_req_o, mem_addr_o, pc_o);
        end
        wait_valid("bp_fetch4", 20);
        checks++; if (inst_o !== 32'h5D5C_5F5E || pc_o !== 32'h4) begin
            errors++; $display("FAIL bp_inst4: got inst=%h pc=%h want 5d5c5f5e/4", inst_o, pc_o);
        end
        ready_i = 1'b1; tick(); ready_i = 1'b0; #1;
    endtask

    task automatic test_gnt_stall();
        logic [7:0]  gnt_tab   = 8'b1111_0011;  // bit c = grant in cycle c
        logic [7:0]  req_tab   = 8'b0011_1111;
        logic [7:0]  valid_tab = 8'b1000_0000;
        logic [31:0] addr_tab [8] = '{32'h8, 32'h9, 32'hA, 32'hA, 32'hA, 32'hB, 32'h0, 32'h0};
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            mem_gnt_i = gnt_tab[c];
            #1;
            checks++; if (mem_req_o !== req_tab[c] || mem_addr_o !== addr_tab[c] || valid_o !== valid_tab[c]) begin
                errors++; $display("FAIL stall_c%0d: got req=%b addr=%h valid=%b want %b/%h/%b", c,
                                   mem_req_o, mem_addr_o, valid_o, req_tab[c], addr_tab[c], valid_tab[c]);
            end
        end
        mem_gnt_i = 1'b1;
        checks++; if (inst_o !== 32'h5150_5352 || pc_o !== 32'h8) begin
            errors++; $display("FAIL stall_inst: got inst=%h pc=%h want 51505352/8", inst_o, pc_o);
        end
        ready_i = 1'b1; tick(); ready_i = 1'b0; #1;
    endtask

    task automatic test_redirect();
        checks++; if (mem_addr_o !== 32'hC) begin errors++; $display("FAIL redir_c0: got %h want c", mem_addr_o); end
        tick(); #1;
        checks++; if (mem_addr_o !== 32'hD) begin errors++; $display("FAIL redir_c1: got %h want d", mem_addr_o); end
        tick(); redirect_i = 1'b1; redirect_pc_i = 32'h103; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_c2_valid: got %b want 0", valid_o); end
        tick(); redirect_i = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin tick(); #1; end
            checks++; if (valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 + 32'(c) || pc_o !== 32'h100) begin
                errors++; $display("FAIL redir_req%0d: got valid=%b req=%b addr=%h pc=%h want 0/1/%h/100", c,
                                   valid_o, mem_req_o, mem_addr_o, pc_o, 32'h100 + 32'(c));
            end
        end
        tick(); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL redir_c4_valid: got %b want 0", valid_o); end
        tick(); #1;
        checks++; if (valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || pc_o !== 32'h100) begin
            errors++; $display("FAIL redir_done: got valid=%b inst=%h pc=%h want 1/00100093/100", valid_o, inst_o, pc_o);
        end
    endtask

    task automatic test_redirect_transfer();
        ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick(); ready_i = 1'b0; redirect_i = 1'b0; #1;
        checks++; if (valid_o !== 1'b0 || pc_o !== 32'h40 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
            errors++; $display("FAIL rx_next: got valid=%b pc=%h req=%b addr=%h want 0/40/1/40", valid_o, pc_o, mem_req_o, mem_addr_o);
        end
        for (int c = 1; c < 4; c++) begin
            tick(); #1;
            checks++; if (mem_addr_o !== 32'h40 + 32'(c)) begin
                errors++; $display("FAIL rx_addr%0d: got %h want %h", c, mem_addr_o, 32'h40 + 32'(c));
            end
        end
        wait_valid("rx_fetch", 20);
        checks++; if (inst_o !== 32'h1918_1B1A) begin errors++; $display("FAIL rx_inst: got %h want 19181b1a", inst_o); end
        ready_i = 1'b1; tick(); ready_i = 1'b0; #1;
    endtask

    task automatic test_redirect_last_byte();
        for (int c = 1; c < 5; c++) begin
            tick();
            if (c == 4) begin redirect_i = 1'b1; redirect_pc_i = 32'h200; end
            #1;
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rlb_c4: got valid=%b want 0", valid_o); end
        tick(); redirect_i = 1'b0; #1;
        checks++; if (valid_o !== 1'b0 || mem_addr_o !== 32'h200 || mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rlb_drop: got valid=%b req=%b addr=%h want 0/1/200", valid_o, mem_req_o, mem_addr_o);
        end
        wait_valid("rlb_fetch", 20);
        checks++; if (inst_o !== 32'h0000_0013 || pc_o !== 32'h200) begin
            errors++; $display("FAIL rlb_inst: got inst=%h pc=%h want 00000013/200", inst_o, pc_o);
        end
        ready_i = 1'b1; tick(); ready_i = 1'b0; #1;
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        tick(); redirect_i = 1'b0; #1;
        checks++; if (pc_o !== 32'hFFFF_FFFC || mem_addr_o !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_align: got pc=%h addr=%h want fffffffc/fffffffc", pc_o, mem_addr_o);
        end
        wait_valid("wrap_fetch", 20);
        checks++; if (inst_o !== 32'hA5A4_A7A6) begin errors++; $display("FAIL wrap_inst: got %h want a5a4a7a6", inst_o); end
        ready_i = 1'b1; tick(); ready_i = 1'b0; #1;
        checks++; if (pc_o !== 32'h0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got pc=%h req=%b addr=%h want 0/1/0", pc_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_rst_midfetch();
        tick(); #1;
        tick(); rst = 1'b1; #1;
        tick(); rst = 1'b0; #1;
        checks++; if (valid_o !== 1'b0 || inst_o !== 32'h0 || pc_o !== 32'h0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_state: got valid=%b inst=%h pc=%h req=%b addr=%h want 0/0/0/1/0",
                               valid_o, inst_o, pc_o, mem_req_o, mem_addr_o);
        end
        for (int c = 0; c < 5; c++) begin tick(); #1; end
        checks++; if (valid_o !== 1'b1 || inst_o !== 32'h0000_0013) begin
            errors++; $display("FAIL rstmid_refetch: got valid=%b inst=%h want 1/00000013", valid_o, inst_o);
        end
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache();
        ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0;
        tick(); ready_i = 1'b0; redirect_i = 1'b0; #1;
        checks++; if (mem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL icache_hit: got req=%b valid=%b want 0/0", mem_req_o, valid_o);
        end
        tick(); #1;
        checks++; if (valid_o !== 1'b1 || inst_o !== 32'h0000_0013 || pc_o !== 32'h0) begin
            errors++; $display("FAIL icache_data: got valid=%b inst=%h pc=%h want 1/00000013/0", valid_o, inst_o, pc_o);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[9'h100] = 8'h93; mem[9'h101] = 8'h00; mem[9'h102] = 8'h10; mem[9'h103] = 8'h00;
        mem_rdata_i = 8'hEE;

        test_reset();
        test_basic();
        test_backpressure();
        test_gnt_stall();
        test_redirect();
        test_redirect_transfer();
        test_redirect_last_byte();
        test_wrap();
        test_rst_midfetch();
`ifdef IF_ICACHE_EN
        test_icache();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_if_fetch

`default_nettype wire
